pipe_skid_stage: RTL and testbench
==================================

# pipe_skid_stage

Parametrised pipeline stage register that replaces the fixed per-stage registers between pipeline stages of the MIPS pipeline CPU. It carries a control bundle and a data bundle with a valid/ready handshake, and has a two-entry skid so that backpressure never creates a combinational ready path. A synchronous flush inserts a bubble by clearing control and valid while leaving data untouched. A saturating stall counter supports performance analysis.

## Interface
- DATA_W, 32: data payload width (operands, immediate, pc4 packed by the instantiating stage)
- CTRL_W, 8: control bundle width (wreg, m2reg, wmem, aluc, aluimm, shift, jal, …); bit 0 is conventionally wreg
- STALL_W, 16: stall counter width
- clk  in  1  clock; all state updates on posedge
- clrn  in  1  reset, asynchronous, active-low
- in_valid  in  1  upstream has a valid entry
- in_ready  out  1  stage can accept; registered
- in_ctrl  in  CTRL_W  upstream control bundle
- in_data  in  DATA_W  upstream data bundle
- out_valid  out  1  head entry valid; registered
- out_ready  in  1  downstream accepts the head entry
- out_ctrl  out  CTRL_W  head control; reads 0 whenever out_valid=0
- out_data  out  DATA_W  head data; holds last value when invalid
- flush  in  1  synchronous kill of all held entries
- clr_stats  in  1  synchronous clear of stall_cnt
- stall_cnt  out  STALL_W  cycles with out_valid=1 and out_ready=0, saturating

## Operation
- Accept: in_valid & in_ready. Emit: out_valid & out_ready.
- The stage holds two entries: main (drives the outputs) and skid.
- States are EMPTY (0 entries), BUSY (main only), and FULL (main+skid). Signal values per state:
  - in_ready = (state != FULL)
  - out_valid = (state != EMPTY)
- EMPTY:
  - accept -> BUSY, main<=in.
- BUSY:
  - accept & emit -> BUSY, main<=in.
  - accept only -> FULL, skid<=in.
  - emit only -> EMPTY, main ctrl<=0.
  - neither -> hold.
- FULL:
  - emit -> BUSY, main<=skid, skid ctrl<=0.
  - No accept is possible because in_ready=0.
- Flush has the highest priority:
  - Next state is EMPTY. Main and skid ctrl are set to 0. Data registers are unchanged.
  - An accept or emit in the flush cycle is discarded. The downstream must treat an emit in the flush cycle as killed, because the flush originates from the same control.
- stall_cnt:
  - Increments by 1 each cycle with out_valid & !out_ready & !flush.
  - Saturates at all-ones and does not wrap.
  - When clr_stats coincides with an increment, the result is 0.
- Ordering is strict FIFO. An entry never emits in its accept cycle (minimum latency 1).

## Timing
- Reset (clrn=0, asynchronous) forces:
  - state=EMPTY, in_ready=1, out_valid=0, out_ctrl=0, out_data=0, skid=0, stall_cnt=0.
- Reset asserted mid-operation discards all entries immediately. There is no partial-cycle behaviour.
- Latency is 1 cycle from accept to out_valid when the stage is empty or is draining in the same cycle.
- Throughput is 1 entry/cycle with out_ready held at 1.
- in_ready is a pure register output. It depends only on the state after the last clock edge, never on out_ready in the same cycle.
- Backpressure timing:
  - After out_ready drops, the stage absorbs exactly one further entry (into skid).
  - in_ready then falls in the following cycle.
- Release timing:
  - On release from FULL, the skid entry moves to main one cycle after the main entry is emitted.
  - in_ready rises in that same cycle.
- Flush in FULL:
  - The next cycle has out_valid=0, out_ctrl=0 and in_ready=1.

## Structure
- Shared package pipe_pkg holds:
  - pipe_state_t: ST_EMPTY=2'd0, ST_BUSY=2'd1, ST_FULL=2'd2.
  - The control-bit index constants used by all stages (CTRL_WREG=0, CTRL_M2REG, CTRL_WMEM, CTRL_JAL …).
- One sub-module, pipe_sat_cnt, implements the saturating stall counter with a synchronous clear (params: WIDTH). It is reusable for other performance counters.
- The control path (state, valid, ctrl) and the data path (data registers, no reset dependency beyond zeroing) are kept in separate always blocks.

## Test plan
- Reset release, then in_valid=1 with ctrl=8'h81, data=32'hDEADBEEF, out_ready=1:
  - Next cycle out_valid=1, out_ctrl=8'h81, out_data=32'hDEADBEEF.
  - 1/cycle streaming of 16 entries with no gaps.
- Backpressure: stream 1,2,3,… and drop out_ready at the cycle 2 is emitted:
  - Entry 3 is absorbed into skid and in_ready=0 the next cycle.
  - On raising out_ready, 3 then 4 emerge in order. No loss or duplication.
- Flush in FULL (main=5, skid=6):
  - Next cycle out_valid=0, out_ctrl=0, out_data still holds 5's data, in_ready=1.
  - Entry 6 never appears.
- Flush coincident with accept of entry 7:
  - 7 is dropped and the state is EMPTY.
  - Entry 8 accepted next cycle emerges with latency 1.
- Stall counter with STALL_W=4: hold out_valid=1, out_ready=0 for 20 cycles:
  - stall_cnt reaches 15 and stays at 15.
  - clr_stats in a stall cycle gives 0, then counting resumes at 1.
- Assert clrn=0 asynchronously mid-cycle in FULL:
  - Outputs go to reset values without waiting for a clock edge.
  - After release the stage is EMPTY with in_ready=1.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage registers: skid state encoding
// and the control-bundle bit positions every stage agrees on.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } pipe_state_t;

    localparam int CTRL_WREG   = 0;
    localparam int CTRL_M2REG  = 1;
    localparam int CTRL_WMEM   = 2;
    localparam int CTRL_ALUIMM = 3;
    localparam int CTRL_SHIFT  = 4;
    localparam int CTRL_JAL    = 5;

endpackage

// File: rtl/pipe_sat_cnt.sv
// Saturating up-counter with a synchronous clear; clear wins over increment.
module pipe_sat_cnt #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != {WIDTH{1'b1}})) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count = cnt_q;

endmodule

// File: rtl/pipe_skid_stage.sv
// Two-entry skid pipeline register with valid/ready handshake, bubble-inserting
// flush and a saturating backpressure (stall) counter.
module pipe_skid_stage
    import pipe_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int CTRL_W  = 8,
    parameter int STALL_W = 16
) (
    input  logic               clk,
    input  logic               clrn,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [CTRL_W-1:0]  in_ctrl,
    input  logic [DATA_W-1:0]  in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CTRL_W-1:0]  out_ctrl,
    output logic [DATA_W-1:0]  out_data,
    input  logic               flush,
    input  logic               clr_stats,
    output logic [STALL_W-1:0] stall_cnt
);

    pipe_state_t       state_q,     state_d;
    logic              in_ready_q,  in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;

    logic accept;
    logic emit;
    logic ld_main_in;
    logic ld_main_skid;
    logic ld_skid_in;
    logic stall_inc;

    assign accept = in_valid & in_ready_q;
    assign emit   = out_valid_q & out_ready;

    // Control path: ctrl of an unoccupied slot is always zero, so out_ctrl
    // reads 0 whenever out_valid is low without any output gating.
    always_comb begin
        state_d      = state_q;
        main_ctrl_d  = main_ctrl_q;
        skid_ctrl_d  = skid_ctrl_q;
        ld_main_in   = 1'b0;
        ld_main_skid = 1'b0;
        ld_skid_in   = 1'b0;
        if (flush) begin
            state_d     = ST_EMPTY;
            main_ctrl_d = '0;
            skid_ctrl_d = '0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d     = ST_BUSY;
                        main_ctrl_d = in_ctrl;
                        ld_main_in  = 1'b1;
                    end
                end
                ST_BUSY: begin
                    if (accept && emit) begin
                        main_ctrl_d = in_ctrl;
                        ld_main_in  = 1'b1;
                    end else if (accept) begin
                        state_d     = ST_FULL;
                        skid_ctrl_d = in_ctrl;
                        ld_skid_in  = 1'b1;
                    end else if (emit) begin
                        state_d     = ST_EMPTY;
                        main_ctrl_d = '0;
                    end
                end
                ST_FULL: begin
                    if (emit) begin
                        state_d      = ST_BUSY;
                        main_ctrl_d  = skid_ctrl_q;
                        skid_ctrl_d  = '0;
                        ld_main_skid = 1'b1;
                    end
                end
                default: begin
                    state_d     = ST_EMPTY;
                    main_ctrl_d = '0;
                    skid_ctrl_d = '0;
                end
            endcase
        end
        in_ready_d  = (state_d != ST_FULL);
        out_valid_d = (state_d != ST_EMPTY);
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q     <= ST_EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            main_ctrl_q <= '0;
            skid_ctrl_q <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            main_ctrl_q <= main_ctrl_d;
            skid_ctrl_q <= skid_ctrl_d;
        end
    end

    // Data path only follows the load strobes; flush leaves it untouched.
    always_comb begin
        main_data_d = main_data_q;
        skid_data_d = skid_data_q;
        if (ld_main_in) begin
            main_data_d = in_data;
        end else if (ld_main_skid) begin
            main_data_d = skid_data_q;
        end
        if (ld_skid_in) begin
            skid_data_d = in_data;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            main_data_q <= '0;
            skid_data_q <= '0;
        end else begin
            main_data_q <= main_data_d;
            skid_data_q <= skid_data_d;
        end
    end

    assign stall_inc = out_valid_q & ~out_ready & ~flush;

    pipe_sat_cnt #(
        .WIDTH (STALL_W)
    ) u_stall_cnt (
        .clk   (clk),
        .clrn  (clrn),
        .inc   (stall_inc),
        .clr   (clr_stats),
        .count (stall_cnt)
    );

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_ctrl  = main_ctrl_q;
    assign out_data  = main_data_q;

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Scoreboard bench for pipe_skid_stage: streaming, backpressure, flush,
// stall counter saturation and asynchronous reset.
`timescale 1ns/1ps
module tb_pipe_skid_stage;

    localparam int DW = 32;
    localparam int CW = 8;
    localparam int SW = 4;

    logic          clk = 1'b0;
    logic          clrn = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [CW-1:0] in_ctrl = '0;
    logic [DW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [CW-1:0] out_ctrl;
    logic [DW-1:0] out_data;
    logic          flush = 1'b0;
    logic          clr_stats = 1'b0;
    logic [SW-1:0] stall_cnt;

    always #5 clk = ~clk;

    pipe_skid_stage #(
        .DATA_W  (DW),
        .CTRL_W  (CW),
        .STALL_W (SW)
    ) dut (
        .clk       (clk),
        .clrn      (clrn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_data  (out_data),
        .flush     (flush),
        .clr_stats (clr_stats),
        .stall_cnt (stall_cnt)
    );

    int total = 0;
    int bad   = 0;

    logic [CW+DW-1:0] sb[$];
    logic [CW+DW-1:0] exp_e;
    logic             s_acc, s_emi, s_rdy, s_vld;
    logic [CW-1:0]    s_ctrl;
    logic [DW-1:0]    s_data;
    logic [SW-1:0]    s_cnt;

    function automatic logic [CW+DW-1:0] entry(input int n);
        return {8'h80 | 8'(n), 32'hA500_0000 + 32'(n)};
    endfunction

    // Drives one cycle's inputs at negedge, samples outputs, ends on posedge.
    task automatic drive_cycle(input logic v, input logic [CW+DW-1:0] e,
                               input logic r, input logic f, input logic cs);
        @(negedge clk);
        in_valid  = v;
        {in_ctrl, in_data} = e;
        out_ready = r;
        flush     = f;
        clr_stats = cs;
        #1;
        s_rdy  = in_ready;
        s_vld  = out_valid;
        s_ctrl = out_ctrl;
        s_data = out_data;
        s_cnt  = stall_cnt;
        s_acc  = v & s_rdy;
        s_emi  = s_vld & r;
        @(posedge clk);
    endtask

    task automatic test_reset();
        clrn = 1'b0;
        repeat (2) @(posedge clk);
        #2 clrn = 1'b1;
        drive_cycle(1'b0, entry(0), 1'b0, 1'b0, 1'b0);
        total++; if (s_rdy !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b required 1", s_rdy); end
        total++; if (s_vld !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b required 0", s_vld); end
        total++; if (s_ctrl !== '0) begin bad++; $display("FAIL reset_out_ctrl: got %h required 00", s_ctrl); end
        total++; if (s_data !== '0) begin bad++; $display("FAIL reset_out_data: got %h required 0", s_data); end
        total++; if (s_cnt !== '0) begin bad++; $display("FAIL reset_stall_cnt: got %0d required 0", s_cnt); end
    endtask

    task automatic test_first();
        logic [CW+DW-1:0] e;
        e = {8'h81, 32'hDEADBEEF};
        sb.delete();
        drive_cycle(1'b1, e, 1'b1, 1'b0, 1'b0);
        total++; if (s_acc !== 1'b1) begin bad++; $display("FAIL first_accept: got %b required 1", s_acc); end
        if (s_acc) sb.push_back(e);
        drive_cycle(1'b0, entry(0), 1'b1, 1'b0, 1'b0);
        total++; if (s_vld !== 1'b1) begin bad++; $display("FAIL first_latency: out_valid got %b required 1", s_vld); end
        if (s_emi) begin
            total++;
            if (sb.size() == 0) begin bad++; $display("FAIL first_emit: got %h required none", {s_ctrl, s_data}); end
            else begin
                exp_e = sb.pop_front();
                if ({s_ctrl, s_data} !== exp_e) begin bad++; $display("FAIL first_emit: got %h required %h", {s_ctrl, s_data}, exp_e); end
            end
        end
        total++; if (sb.size() != 0) begin bad++; $display("FAIL first_drain: pending got %0d required 0", sb.size()); end
    endtask

    task automatic test_stream();
        logic [CW+DW-1:0] e;
        sb.delete();
        for (int i = 0; i < 17; i++) begin
            e = entry(i + 1);
            drive_cycle(i < 16, e, 1'b1, 1'b0, 1'b0);
            if (i < 16) begin
                total++; if (s_acc !== 1'b1) begin bad++; $display("FAIL stream_gap_in: cycle %0d accept got %b required 1", i, s_acc); end
            end
            if (i > 0) begin
                total++; if (s_emi !== 1'b1) begin bad++; $display("FAIL stream_gap_out: cycle %0d emit got %b required 1", i, s_emi); end
            end
            if (s_emi) begin
                total++;
                if (sb.size() == 0) begin bad++; $display("FAIL stream_emit: got %h required none", {s_ctrl, s_data}); end
                else begin
                    exp_e = sb.pop_front();
                    if ({s_ctrl, s_data} !== exp_e) begin bad++; $display("FAIL stream_emit: got %h required %h", {s_ctrl, s_data}, exp_e); end
                end
            end
            if (s_acc) sb.push_back(e);
        end
        total++; if (sb.size() != 0) begin bad++; $display("FAIL stream_drain: pending got %0d required 0", sb.size()); end
    endtask

    task automatic test_backpressure();
        logic [CW+DW-1:0] e;
        logic [CW+DW-1:0] e3;
        int nid;
        nid = 1;
        e3 = entry(3);
        sb.delete();
        for (int c = 0; c < 20; c++) begin
            e = entry(nid);
            drive_cycle(nid <= 8, e, !(c >= 2 && c < 5), 1'b0, 1'b0);
            if (c == 2) begin
                total++; if (s_acc !== 1'b1) begin bad++; $display("FAIL bp_skid_absorb: accept got %b required 1", s_acc); end
            end
            if (c == 3) begin
                total++; if (s_rdy !== 1'b0) begin bad++; $display("FAIL bp_ready_low: in_ready got %b required 0", s_rdy); end
            end
            if (c == 6) begin
                total++; if (s_rdy !== 1'b1) begin bad++; $display("FAIL bp_ready_release: in_ready got %b required 1", s_rdy); end
                total++; if ({s_ctrl, s_data} !== e3) begin bad++; $display("FAIL bp_skid_to_main: got %h required %h", {s_ctrl, s_data}, e3); end
            end
            if (s_emi) begin
                total++;
                if (sb.size() == 0) begin bad++; $display("FAIL bp_emit: got %h required none", {s_ctrl, s_data}); end
                else begin
                    exp_e = sb.pop_front();
                    if ({s_ctrl, s_data} !== exp_e) begin bad++; $display("FAIL bp_emit: got %h required %h", {s_ctrl, s_data}, exp_e); end
                end
            end
            if (s_acc) begin
                sb.push_back(e);
                nid++;
            end
        end
        total++; if (nid != 9 || sb.size() != 0) begin bad++; $display("FAIL bp_complete: next id %0d pending %0d required 9 and 0", nid, sb.size()); end
    endtask

    task automatic test_flush_full();
        logic [CW-1:0] c5;
        logic [DW-1:0] d5;
        {c5, d5} = entry(5);
        sb.delete();
        drive_cycle(1'b1, entry(5), 1'b0, 1'b0, 1'b0);
        drive_cycle(1'b1, entry(6), 1'b0, 1'b0, 1'b0);
        drive_cycle(1'b0, entry(0), 1'b0, 1'b1, 1'b0);
        total++; if (s_rdy !== 1'b0 || s_ctrl !== c5) begin bad++; $display("FAIL flush_setup_full: in_ready %b ctrl %h required 0 and %h", s_rdy, s_ctrl, c5); end
        drive_cycle(1'b0, entry(0), 1'b1, 1'b0, 1'b0);
        total++; if (s_vld !== 1'b0) begin bad++; $display("FAIL flush_out_valid: got %b required 0", s_vld); end
        total++; if (s_ctrl !== '0) begin bad++; $display("FAIL flush_out_ctrl: got %h required 00", s_ctrl); end
        total++; if (s_data !== d5) begin bad++; $display("FAIL flush_data_hold: got %h required %h", s_data, d5); end
        total++; if (s_rdy !== 1'b1) begin bad++; $display("FAIL flush_in_ready: got %b required 1", s_rdy); end
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b0, entry(0), 1'b1, 1'b0, 1'b0);
            total++; if (s_emi !== 1'b0) begin bad++; $display("FAIL flush_skid_killed: got %h emitted required none", {s_ctrl, s_data}); end
        end
    endtask

    task automatic test_flush_accept();
        logic [CW+DW-1:0] e;
        sb.delete();
        drive_cycle(1'b1, entry(7), 1'b1, 1'b1, 1'b0);
        e = entry(8);
        drive_cycle(1'b1, e, 1'b1, 1'b0, 1'b0);
        total++; if (s_vld !== 1'b0 || s_rdy !== 1'b1) begin bad++; $display("FAIL flush_acc_empty: out_valid %b in_ready %b required 0 and 1", s_vld, s_rdy); end
        if (s_acc) sb.push_back(e);
        drive_cycle(1'b0, entry(0), 1'b1, 1'b0, 1'b0);
        total++; if (s_vld !== 1'b1) begin bad++; $display("FAIL flush_acc_latency: out_valid got %b required 1", s_vld); end
        if (s_emi) begin
            total++;
            if (sb.size() == 0) begin bad++; $display("FAIL flush_acc_emit: got %h required none", {s_ctrl, s_data}); end
            else begin
                exp_e = sb.pop_front();
                if ({s_ctrl, s_data} !== exp_e) begin bad++; $display("FAIL flush_acc_emit: got %h required %h", {s_ctrl, s_data}, exp_e); end
            end
        end
        drive_cycle(1'b0, entry(0), 1'b1, 1'b0, 1'b0);
        total++; if (s_vld !== 1'b0) begin bad++; $display("FAIL flush_acc_no_extra: out_valid got %b required 0", s_vld); end
    endtask

    task automatic test_stall();
        logic [CW+DW-1:0] e;
        logic [SW-1:0]    exp_cnt;
        sb.delete();
        e = entry(9);
        drive_cycle(1'b1, e, 1'b0, 1'b0, 1'b1);
        if (s_acc) sb.push_back(e);
        for (int i = 0; i < 20; i++) begin
            drive_cycle(1'b0, entry(0), 1'b0, 1'b0, 1'b0);
            exp_cnt = (i < 15) ? SW'(i) : SW'(15);
            total++; if (s_cnt !== exp_cnt) begin bad++; $display("FAIL stall_count: cycle %0d got %0d required %0d", i, s_cnt, exp_cnt); end
        end
        drive_cycle(1'b0, entry(0), 1'b0, 1'b0, 1'b1);
        drive_cycle(1'b0, entry(0), 1'b0, 1'b0, 1'b0);
        total++; if (s_cnt !== '0) begin bad++; $display("FAIL stall_clear: got %0d required 0", s_cnt); end
        drive_cycle(1'b0, entry(0), 1'b1, 1'b0, 1'b0);
        total++; if (s_cnt !== SW'(1)) begin bad++; $display("FAIL stall_resume: got %0d required 1", s_cnt); end
        if (s_emi) begin
            total++;
            if (sb.size() == 0) begin bad++; $display("FAIL stall_emit: got %h required none", {s_ctrl, s_data}); end
            else begin
                exp_e = sb.pop_front();
                if ({s_ctrl, s_data} !== exp_e) begin bad++; $display("FAIL stall_emit: got %h required %h", {s_ctrl, s_data}, exp_e); end
            end
        end
        total++; if (sb.size() != 0) begin bad++; $display("FAIL stall_drain: pending got %0d required 0", sb.size()); end
    endtask

    task automatic test_async_reset();
        logic [CW+DW-1:0] e;
        sb.delete();
        drive_cycle(1'b1, entry(10), 1'b0, 1'b0, 1'b0);
        drive_cycle(1'b1, entry(11), 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        total++; if (in_ready !== 1'b0 || stall_cnt === '0) begin bad++; $display("FAIL areset_setup: in_ready %b stall_cnt %0d required 0 and nonzero", in_ready, stall_cnt); end
        #1 clrn = 1'b0;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL areset_in_ready: got %b required 1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL areset_out_valid: got %b required 0", out_valid); end
        total++; if (out_ctrl !== '0) begin bad++; $display("FAIL areset_out_ctrl: got %h required 00", out_ctrl); end
        total++; if (out_data !== '0) begin bad++; $display("FAIL areset_out_data: got %h required 0", out_data); end
        total++; if (stall_cnt !== '0) begin bad++; $display("FAIL areset_stall_cnt: got %0d required 0", stall_cnt); end
        @(posedge clk);
        #2 clrn = 1'b1;
        drive_cycle(1'b0, entry(0), 1'b1, 1'b0, 1'b0);
        total++; if (s_rdy !== 1'b1 || s_vld !== 1'b0) begin bad++; $display("FAIL areset_empty: in_ready %b out_valid %b required 1 and 0", s_rdy, s_vld); end
        e = entry(12);
        drive_cycle(1'b1, e, 1'b1, 1'b0, 1'b0);
        if (s_acc) sb.push_back(e);
        drive_cycle(1'b0, entry(0), 1'b1, 1'b0, 1'b0);
        total++; if (s_emi !== 1'b1) begin bad++; $display("FAIL areset_resume: emit got %b required 1", s_emi); end
        if (s_emi) begin
            total++;
            if (sb.size() == 0) begin bad++; $display("FAIL areset_emit: got %h required none", {s_ctrl, s_data}); end
            else begin
                exp_e = sb.pop_front();
                if ({s_ctrl, s_data} !== exp_e) begin bad++; $display("FAIL areset_emit: got %h required %h", {s_ctrl, s_data}, exp_e); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_first();
        test_stream();
        test_backpressure();
        test_flush_full();
        test_flush_accept();
        test_stall();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
